// File: rtl/mips32_mem_responder_if.sv
// Request/acknowledge bus between the MIPS32 core (master) and the
// memory responder (slave): one instruction port and one data port.
interface mips32_mem_responder_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err
   );
endinterface

// File: rtl/mips32_mem_responder.sv
// Memory responder for MIPS32 instruction fetch and load/store traffic.
// Owns a DEPTH x 32 word array and serves the I and D ports through a
// req/ack handshake with WAIT_CYCLES extra wait states per access.
// Simultaneous requests are ordered round-robin (D wins the first tie).
// Optional feature: define MEM_ERR_EN to flag addresses with any bit of
// addr[31:AW] set as errors (store suppressed, read data 0); otherwise
// addresses wrap modulo DEPTH and the err outputs stay 0.
module mips32_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int AW          = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   mips32_mem_responder_if.slave    bus,
   output logic                     busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WAIT   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   logic [1:0]    state;
   logic [3:0]    wait_cnt;
   logic          last_d;
   logic          cap_d;
   logic          cap_we;
   logic          cap_err;
   logic [AW-1:0] cap_idx;
   logic [31:0]   cap_wdata;
   logic [31:0]   mem [DEPTH];

   logic          grant_d;
   logic [31:0]   sel_addr;
   logic          sel_err;

   // Port selection and address check for the request being sampled in IDLE
   always_comb begin
      grant_d  = bus.d_req && (!bus.i_req || !last_d);
      sel_addr = grant_d ? bus.d_addr : bus.i_addr;
`ifdef MEM_ERR_EN
      sel_err  = |sel_addr[31:AW];
`else
      sel_err  = 1'b0;
`endif
   end

   assign busy = (state != IDLE);

   // Transaction FSM, capture registers and per-port response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         last_d      <= 1'b0;
         cap_d       <= 1'b0;
         cap_we      <= 1'b0;
         cap_err     <= 1'b0;
         cap_idx     <= '0;
         cap_wdata   <= '0;
         bus.i_ack   <= 1'b0;
         bus.i_err   <= 1'b0;
         bus.i_rdata <= '0;
         bus.d_ack   <= 1'b0;
         bus.d_err   <= 1'b0;
         bus.d_rdata <= '0;
      end else begin
         bus.i_ack <= 1'b0;
         bus.d_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_req || bus.d_req) begin
                  cap_d     <= grant_d;
                  cap_we    <= grant_d && bus.d_we;
                  cap_err   <= sel_err;
                  cap_idx   <= sel_addr[AW-1:0];
                  cap_wdata <= bus.d_wdata;
                  wait_cnt  <= WAIT_INIT;
                  state     <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) state <= ACCESS;
            end
            ACCESS: begin
               if (cap_d) begin
                  bus.d_ack <= 1'b1;
                  bus.d_err <= cap_err;
                  if (!cap_we) bus.d_rdata <= cap_err ? '0 : mem[cap_idx];
               end else begin
                  bus.i_ack   <= 1'b1;
                  bus.i_err   <= cap_err;
                  bus.i_rdata <= cap_err ? '0 : mem[cap_idx];
               end
               last_d <= cap_d;
               state  <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Array write at the ACCESS edge; a reset on the same edge cancels it
   always_ff @(posedge clk) begin
      if (!rst && state == ACCESS && cap_we && !cap_err) mem[cap_idx] <= cap_wdata;
   end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Self-checking bench for mips32_mem_responder: a WAIT_CYCLES=1 instance for
// most scenarios and a WAIT_CYCLES=0 instance for the zero-wait fetch.
module tb_mips32_mem_responder;
   localparam int W  = 1;
   localparam int AW = 10;
`ifdef MEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic busy, busyz;
   always #5 clk = ~clk;

   mips32_mem_responder_if bus ();
   mips32_mem_responder_if busz ();

   mips32_mem_responder #(.DEPTH(1024), .AW(AW), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy));
   mips32_mem_responder #(.DEPTH(1024), .AW(AW), .WAIT_CYCLES(0)) dutz (
      .clk(clk), .rst(rst), .bus(busz), .busy(busyz));

   int errors = 0;
   int checks = 0;
   logic [31:0] model [int];
   logic [31:0] exp_i_rdata = '0;
   logic [31:0] exp_d_rdata = '0;

   function automatic bit is_err(input logic [31:0] a);
      return ERR_EN && ((a >> AW) != 0);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'(a % 1024);
   endfunction

   // One transaction on the W=1 instance, starting with the DUT idle
   task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat,
                          output logic [31:0] rdata, output logic err,
                          output logic [31:0] other_rdata, output logic ack_after);
      @(negedge clk);
      if (is_d) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
      end else begin
         bus.i_req = 1'b1; bus.i_addr = addr;
      end
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if ((is_d ? bus.d_ack : bus.i_ack) === 1'b1) begin
            lat = k;
            break;
         end
      end
      rdata       = is_d ? bus.d_rdata : bus.i_rdata;
      err         = is_d ? bus.d_err : bus.i_err;
      other_rdata = is_d ? bus.i_rdata : bus.d_rdata;
      bus.d_req = 1'b0; bus.i_req = 1'b0; bus.d_we = 1'b0;
      bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.i_addr = $urandom;
      @(negedge clk);
      ack_after = is_d ? bus.d_ack : bus.i_ack;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      busz.i_req = 0; busz.i_addr = '0; busz.d_req = 0; busz.d_we = 0; busz.d_addr = '0; busz.d_wdata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%h %h %h %h %h %h %h required all 0", bus.i_ack, bus.d_ack,
                  bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata, busy);
      end
      checks++;
      if ({busz.i_ack, busz.d_ack, busz.i_err, busz.d_err, busz.i_rdata, busz.d_rdata, busyz} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_w0 got=%h %h %h %h %h %h %h required all 0", busz.i_ack, busz.d_ack,
                  busz.i_err, busz.d_err, busz.i_rdata, busz.d_rdata, busyz);
      end
      rst = 1'b0;
      exp_i_rdata = '0; exp_d_rdata = '0;
   endtask

   task automatic test_store_load();
      logic [7:0] got_busy, exp_busy, got_ack, exp_ack;
      int lat; logic [31:0] rd, oth; logic er, aa;
      got_busy = '0; exp_busy = '0; got_ack = '0; exp_ack = '0;
      @(negedge clk);
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'd5; bus.d_wdata = 32'hDEADBEEF;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL store_busy_c0 got=%b required=0", busy); end
      for (int k = 1; k <= 3 + W; k++) begin
         @(negedge clk);
         got_busy[k] = busy;   exp_busy[k] = (k <= 2 + W);
         got_ack[k]  = bus.d_ack; exp_ack[k] = (k == 2 + W);
         if (k == 2 + W) begin bus.d_req = 0; bus.d_we = 0; end
      end
      model[5] = 32'hDEADBEEF;
      checks++;
      if (got_busy !== exp_busy) begin errors++; $display("FAIL store_busy_profile got=%b required=%b", got_busy, exp_busy); end
      checks++;
      if (got_ack !== exp_ack) begin errors++; $display("FAIL store_ack_profile got=%b required=%b", got_ack, exp_ack); end
      run_txn(1, 0, 32'd5, 32'h0, lat, rd, er, oth, aa);
      checks++;
      if (lat !== 2 + W) begin errors++; $display("FAIL load_latency got=%0d required=%0d", lat, 2 + W); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got=%h required=deadbeef", rd); end
      checks++;
      if ({er, aa} !== 2'b00) begin errors++; $display("FAIL load_err_pulse got=%b required=00", {er, aa}); end
      exp_d_rdata = 32'hDEADBEEF;
   endtask

   task automatic test_fetch_w0();
      int ki;
      @(negedge clk);
      busz.d_req = 1; busz.d_we = 1; busz.d_addr = 32'd8; busz.d_wdata = 32'hFC000000;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (busz.d_ack === 1'b1) break;
      end
      busz.d_req = 0; busz.d_we = 0;
      @(negedge clk);
      busz.i_req = 1; busz.i_addr = 32'd8;
      ki = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (busz.i_ack === 1'b1) begin ki = k; break; end
      end
      busz.i_req = 0; busz.i_addr = 32'hFFFF_FFFF;
      checks++;
      if (ki !== 2) begin errors++; $display("FAIL w0_fetch_latency got=%0d required=2", ki); end
      checks++;
      if ({busz.i_rdata, busz.i_err} !== {32'hFC000000, 1'b0}) begin
         errors++; $display("FAIL w0_fetch_rdata got=%h err=%b required=fc000000 err=0", busz.i_rdata, busz.i_err);
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({busz.i_rdata, busz.i_ack} !== {32'hFC000000, 1'b0}) begin
         errors++; $display("FAIL w0_fetch_hold got=%h ack=%b required=fc000000 ack=0", busz.i_rdata, busz.i_ack);
      end
   endtask

   task automatic test_err_wrap();
      int lat; logic [31:0] rd, oth; logic er, aa;
      logic [31:0] exp0;
      run_txn(1, 1, 32'd0, 32'hA5A5A5A5, lat, rd, er, oth, aa);
      model[0] = 32'hA5A5A5A5;
      run_txn(1, 1, 32'd1024, 32'h1234, lat, rd, er, oth, aa);
      checks++;
      if (lat !== 2 + W) begin errors++; $display("FAIL err_store_latency got=%0d required=%0d", lat, 2 + W); end
      checks++;
      if (er !== ERR_EN) begin errors++; $display("FAIL err_store_flag got=%b required=%b", er, ERR_EN); end
      exp0 = ERR_EN ? 32'hA5A5A5A5 : 32'h1234;
      model[0] = exp0;
      run_txn(1, 0, 32'd0, 32'h0, lat, rd, er, oth, aa);
      checks++;
      if (rd !== exp0) begin errors++; $display("FAIL err_addr0_contents got=%h required=%h", rd, exp0); end
      exp_d_rdata = exp0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         bit is_d, we, e;
         logic [31:0] addr, wdata, exp_r, rd, oth;
         logic er, aa;
         int lat;
         is_d  = ($urandom_range(0, 2) != 0);
         we    = is_d && ($urandom_range(0, 1) == 1);
         addr  = $urandom_range(0, 31);
         if ($urandom_range(0, 5) == 0) addr = addr | (32'h1 << $urandom_range(AW, 31));
         wdata = $urandom;
         e     = is_err(addr);
         if (!we && !e && !model.exists(widx(addr))) begin is_d = 1; we = 1; end
         exp_r = (e || we) ? 32'h0 : model[widx(addr)];
         run_txn(is_d, we, addr, wdata, lat, rd, er, oth, aa);
         checks++;
         if (lat !== 2 + W || aa !== 1'b0) begin
            errors++; $display("FAIL rnd_latency n=%0d got=%0d ack_after=%b required=%0d ack_after=0", n, lat, aa, 2 + W);
         end
         checks++;
         if (er !== e) begin errors++; $display("FAIL rnd_err n=%0d addr=%h got=%b required=%b", n, addr, er, e); end
         if (we) begin
            if (!e) model[widx(addr)] = wdata;
         end else if (is_d) exp_d_rdata = exp_r;
         else exp_i_rdata = exp_r;
         checks++;
         if (rd !== (is_d ? exp_d_rdata : exp_i_rdata)) begin
            errors++; $display("FAIL rnd_rdata n=%0d port=%s we=%b addr=%h got=%h required=%h", n, is_d ? "D" : "I",
                               we, addr, rd, is_d ? exp_d_rdata : exp_i_rdata);
         end
         checks++;
         if (oth !== (is_d ? exp_i_rdata : exp_d_rdata)) begin
            errors++; $display("FAIL rnd_other_hold n=%0d got=%h required=%h", n, oth, is_d ? exp_i_rdata : exp_d_rdata);
         end
      end
   endtask

   task automatic test_arbitration();
      int per, first, last;
      logic [1:0] exp_acks;
      per = 3 + W; first = 2 + W; last = first + 3 * per;
      @(negedge clk);
      rst = 1;
      bus.i_req = 1; bus.i_addr = 32'd5; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'd5;
      @(negedge clk);
      rst = 0;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         exp_acks = 2'b00;
         if (k >= first && (k - first) % per == 0) exp_acks = (((k - first) / per) % 2 == 0) ? 2'b01 : 2'b10;
         checks++;
         if ({bus.i_ack, bus.d_ack} !== exp_acks) begin
            errors++; $display("FAIL arb_order cycle=%0d got i,d=%b required=%b", k, {bus.i_ack, bus.d_ack}, exp_acks);
         end
         if (exp_acks != 2'b00) begin
            checks++;
            if ((exp_acks[0] ? bus.d_rdata : bus.i_rdata) !== model[5]) begin
               errors++; $display("FAIL arb_rdata cycle=%0d got=%h required=%h", k,
                                  exp_acks[0] ? bus.d_rdata : bus.i_rdata, model[5]);
            end
         end
      end
      bus.i_req = 0; bus.d_req = 0;
      exp_i_rdata = model[5]; exp_d_rdata = model[5];
      @(negedge clk);
   endtask

   task automatic test_reset_mid_store();
      int lat; logic [31:0] rd, oth; logic er, aa;
      int hit [2];
      logic [31:0] val [2];
      hit[0] = 1; hit[1] = 1 + W; val[0] = 32'h22; val[1] = 32'h33;
      run_txn(1, 1, 32'd3, 32'h11, lat, rd, er, oth, aa);
      model[3] = 32'h11;
      for (int v = 0; v < 2; v++) begin
         @(negedge clk);
         bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'd3; bus.d_wdata = val[v];
         repeat (hit[v]) @(negedge clk);
         rst = 1; bus.d_req = 0; bus.d_we = 0;
         @(negedge clk);
         checks++;
         if ({bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata, busy} !== '0) begin
            errors++; $display("FAIL midrst_outputs v=%0d got=%h %h %h %h %h %h %h required all 0", v, bus.i_ack,
                               bus.d_ack, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata, busy);
         end
         rst = 0;
         exp_i_rdata = '0; exp_d_rdata = '0;
         run_txn(1, 0, 32'd3, 32'h0, lat, rd, er, oth, aa);
         checks++;
         if (rd !== 32'h11) begin errors++; $display("FAIL midrst_contents v=%0d got=%h required=11", v, rd); end
         exp_d_rdata = 32'h11;
      end
   endtask

   task automatic test_load_during_fetch();
      int ki, kd;
      logic [31:0] i_at_d, d_at_d;
      ki = -1; kd = -1; i_at_d = 'x; d_at_d = 'x;
      @(negedge clk);
      bus.i_req = 1; bus.i_addr = 32'd5;
      @(negedge clk);
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'd3;
      for (int k = 2; k <= 30; k++) begin
         @(negedge clk);
         if (bus.i_ack === 1'b1 && ki < 0) begin ki = k; bus.i_req = 0; end
         if (bus.d_ack === 1'b1) begin
            kd = k; i_at_d = bus.i_rdata; d_at_d = bus.d_rdata; bus.d_req = 0;
            break;
         end
      end
      bus.i_req = 0; bus.d_req = 0;
      checks++;
      if (ki !== 2 + W) begin errors++; $display("FAIL ovl_i_latency got=%0d required=%0d", ki, 2 + W); end
      checks++;
      if (kd - ki !== 3 + W) begin errors++; $display("FAIL ovl_d_gap got=%0d required=%0d", kd - ki, 3 + W); end
      checks++;
      if (i_at_d !== model[5]) begin errors++; $display("FAIL ovl_i_hold got=%h required=%h", i_at_d, model[5]); end
      checks++;
      if (d_at_d !== model[3]) begin errors++; $display("FAIL ovl_d_rdata got=%h required=%h", d_at_d, model[3]); end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_store_load();
      test_fetch_w0();
      test_err_wrap();
      test_random();
      test_arbitration();
      test_reset_mid_store();
      test_load_during_fetch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mips32_mem_responder.md
# mips32_mem_responder

Memory-side responder for the MIPS32 pipeline's instruction-fetch and load/store accesses. It owns the 32-bit word-addressed memory array and serves two requester ports, instruction (I) and data (D), through a req/ack handshake. Each port sees a fixed, parameterised access latency. When both ports request at once, a round-robin arbiter decides the order. The block sits between the CPU core and its memory, so the core can be stalled by wait states instead of assuming a zero-latency array.

## Interface
- DEPTH, 1024, number of 32-bit words in the array
- AW, 10, index width; DEPTH = 2**AW
- WAIT_CYCLES, 1, extra wait-state cycles per access; legal range 0..15
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- i_req  input  1  instruction-port request
- i_addr  input  32  instruction word address
- i_ack  output  1  one-cycle completion pulse, I port
- i_rdata  output  32  fetched word; valid in ack cycle, held until next I ack
- i_err  output  1  address error, qualified by i_ack
- d_req  input  1  data-port request
- d_we  input  1  1 = store, 0 = load
- d_addr  input  32  data word address
- d_wdata  input  32  store data
- d_ack  output  1  one-cycle completion pulse, D port
- d_rdata  output  32  load data; valid in ack cycle, held until next D load ack; unchanged by stores
- d_err  output  1  address error, qualified by d_ack
- busy  output  1  high whenever FSM is not IDLE

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: requests are sampled here only.
  - One request pending: grant that port.
  - Both pending: grant the port not served last. After reset, last-served = I, so D wins the first tie.
  - On grant, capture port id, address, we, wdata and load the 4-bit wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else ACCESS.
- WAIT: counter decrements each cycle; go to ACCESS on the cycle the counter reaches 1.
- ACCESS: at the closing edge:
  - Perform the array read or write at the captured index.
  - For a read, register the data into the granted port's rdata.
  - Set the granted port's ack and err.
  - Update last-served.
  - Go to RESP.
- RESP: ack is high for exactly this cycle; next state is IDLE. Requests are not sampled in RESP.
- Requester rules:
  - Hold req, addr, we and wdata stable until ack.
  - At the edge ending the ack cycle, either drop req or present a new request.
  - A req still high in the following IDLE cycle is a new transaction.
- Inputs may change freely after capture; only captured values are used.
- Only the D port writes. I-port requests are always reads.
- Reset:
  - rst dominates every state. The FSM returns to IDLE; counter = 0; last-served = I.
  - All outputs clear to 0: i_ack, d_ack, i_err, d_err, i_rdata, d_rdata, busy.
  - Array contents are not cleared.
  - A transaction interrupted by reset is dropped. A store whose ACCESS edge coincides with rst is not written.

## Timing
- A request sampled in IDLE at cycle 0 gets its ack in cycle 2+WAIT_CYCLES.
- Occupancy is 3+WAIT_CYCLES cycles per transaction. With both ports continuously requesting, grants alternate D, I, D, I.
- A losing port's request waits one full transaction. Maximum ack latency from req is 2·(3+WAIT_CYCLES)−1 cycles.
- A store completes at the ACCESS edge. A load issued afterwards on either port returns the new data.
- busy rises the cycle after grant and falls in the cycle after RESP.

## Configuration
- MEM_ERR_EN defined:
  - An address with any bit of addr[31:AW] set is an error.
  - The access acks with the same latency and err=1.
  - Stores are suppressed; loads and fetches return rdata = 0.
- MEM_ERR_EN undefined:
  - i_err and d_err are tied to 0.
  - The address is truncated to addr[AW-1:0], so it wraps modulo DEPTH.

## Test plan
- WAIT_CYCLES=1, D store 0xDEADBEEF to addr 5 at cycle 0 -> d_ack high in cycle 3 only; busy high cycles 1-3; then a D load from addr 5 -> d_rdata=0xDEADBEEF with d_ack.
- WAIT_CYCLES=0, I fetch from addr 8 preloaded with 0xFC000000 -> i_ack in cycle 2, i_rdata=0xFC000000, held after the ack drops.
- i_req and d_req both held high from reset, WAIT_CYCLES=1 -> ack order d,i,d,i with acks 4 cycles apart; the first d_ack is in cycle 3.
- MEM_ERR_EN defined, D store of 0x1234 to addr 1024 -> d_ack with d_err=1; addr 0 unchanged. Without the macro, the same store writes addr 0.
- Store to addr 3 (old 0x11, new 0x22), rst pulsed during WAIT -> no ack, all outputs 0 next cycle, addr 3 still reads 0x11.
- D load requested while an I fetch is in progress -> d_ack exactly 3+WAIT_CYCLES cycles after i_ack's RESP-entry edge; the i_rdata value is preserved.
